// File: rtl/count_ones_sd_pkg.sv
// Shared types and default parameters for the sequential ones-counter.
package count_ones_sd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_COUNTER_SIZE = 3;
  localparam int DEF_WORD_SIZE    = 4;

  // Width of a register able to index word_size bits (at least 1 bit).
  function automatic int idx_width(input int word_size);
    return (word_size > 1) ? $clog2(word_size) : 1;
  endfunction

endpackage

// File: rtl/count_ones_sd.sv
// Purpose: loads a word, counts its set bits one per clock, strobes done; repeats forever.
// Latency: done rises word_size+1 cycles after start; period word_size+2 cycles.
// Backpressure: none; free-running, consumers must take bit_count on the done cycle.
module count_ones_sd
  import count_ones_sd_pkg::*;
#(
  parameter int counter_size = DEF_COUNTER_SIZE,
  parameter int word_size    = DEF_WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [counter_size-1:0] bit_count,
  output logic                    start,
  output logic                    done,
  input  logic [word_size-1:0]    data
);

  localparam int IDX_W = idx_width(word_size);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(word_size - 1);

  generate
    if (word_size < 1) begin : g_bad_word
      $error("count_ones_sd: word_size must be at least 1");
    end
    if ((2 ** counter_size) <= word_size) begin : g_bad_counter
      $error("count_ones_sd: counter_size too small to hold a count of word_size");
    end
  endgenerate

  state_t                 state;
  logic [word_size-1:0]   shift_reg;
  logic [IDX_W-1:0]       bit_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_count <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          shift_reg <= data;
          bit_count <= '0;
          bit_idx   <= '0;
          state     <= S_COUNT;
        end
        S_COUNT: begin
          // Fixed-length count: no early exit even if the remaining bits are zero.
          bit_count <= bit_count + counter_size'(shift_reg[0]);
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode straight from the state register keeps both strobes glitch-free.
  assign start = (state == S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_count_ones_sd.sv
// Directed bench for count_ones_sd: default 4-bit instance plus an 8-bit parameter instance.
module tb_count_ones_sd;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset8;
  logic [3:0] data;
  logic [7:0] data8;
  logic [2:0] bit_count;
  logic [3:0] bit_count8;
  logic       start, done, start8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_ones_sd #(.counter_size(3), .word_size(4)) dut (
    .clk(clk), .reset(reset), .bit_count(bit_count),
    .start(start), .done(done), .data(data)
  );

  count_ones_sd #(.counter_size(4), .word_size(8)) dut8 (
    .clk(clk), .reset(reset8), .bit_count(bit_count8),
    .start(start8), .done(done8), .data(data8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a start cycle: counts d, optionally changes data after the load edge.
  task automatic run_word(input string tag, input logic [3:0] d, input logic [2:0] exp,
                          input logic chg, input logic [3:0] new_d);
    data = d;
    check({tag, "_start"}, {7'd0, start}, 8'd1);
    step();
    if (chg) data = new_d;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_busy%0d", tag, i), {6'd0, start, done}, 8'd0);
      step();
    end
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_dstart"}, {7'd0, start}, 8'd0);
    check({tag, "_count"}, {5'd0, bit_count}, {5'd0, exp});
    step();
    check({tag, "_next_start"}, {6'd0, start, done}, 8'd2);
    check({tag, "_hold"}, {5'd0, bit_count}, {5'd0, exp});
  endtask

  initial begin
    int n;
    bit seen;
    reset  = 1'b0;
    reset8 = 1'b0;
    data   = 4'hf;
    data8  = 8'hff;

    // Reset held for several cycles: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rst_hold_start%0d", i), {7'd0, start}, 8'd1);
      check($sformatf("rst_hold_done%0d", i), {7'd0, done}, 8'd0);
      check($sformatf("rst_hold_cnt%0d", i), {5'd0, bit_count}, 8'd0);
      check($sformatf("rst8_hold_done%0d", i), {7'd0, done8}, 8'd0);
    end
    reset = 1'b1;

    // Held all-ones word, repeats with a 6-cycle period.
    run_word("f0", 4'hf, 3'd4, 1'b0, 4'h0);
    run_word("f1", 4'hf, 3'd4, 1'b0, 4'h0);

    run_word("a", 4'ha, 3'd2, 1'b0, 4'h0);
    run_word("5", 4'h5, 3'd2, 1'b0, 4'h0);
    run_word("b", 4'hb, 3'd3, 1'b0, 4'h0);
    run_word("9", 4'h9, 3'd2, 1'b0, 4'h0);
    run_word("0", 4'h0, 3'd0, 1'b0, 4'h0);
    run_word("c", 4'hc, 3'd2, 1'b0, 4'h0);
    run_word("d", 4'hd, 3'd3, 1'b0, 4'h0);
    run_word("7", 4'h7, 3'd3, 1'b0, 4'h0);

    // Data changes during counting are ignored until the next start.
    run_word("chg", 4'h0, 3'd0, 1'b1, 4'hf);
    run_word("chg_next", 4'hf, 3'd4, 1'b0, 4'h0);

    // One-edge reset in the middle of a count aborts it.
    data = 4'hb;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_start", {7'd0, start}, 8'd1);
    check("midrst_done", {7'd0, done}, 8'd0);
    check("midrst_cnt", {5'd0, bit_count}, 8'd0);
    run_word("after_rst", 4'hb, 3'd3, 1'b0, 4'h0);

    // 8-bit instance: done 9 cycles after start with a count of 8.
    reset8 = 1'b1;
    check("w8_start", {7'd0, start8}, 8'd1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      n++;
      if (done8) seen = 1'b1;
    end
    check("w8_seen_done", {7'd0, seen}, 8'd1);
    check("w8_latency", n[7:0], 8'd9);
    check("w8_count", {4'd0, bit_count8}, 8'd8);
    step();
    check("w8_restart", {6'd0, start8, done8}, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
